// File: rtl/prio_dec_4to2_seq_if.sv
// prio_dec_4to2_seq_if: index handshake and one-hot result bundle for prio_dec_4to2_seq
interface prio_dec_4to2_seq_if #(parameter int N = 2);
  logic [N-1:0] in_idx;
  logic in_valid;
  logic in_ready;
  logic [2**N-1:0] dout;
  logic dout_valid;
  logic busy;
  logic [7:0] ev_cnt;
  modport master(output in_idx, in_valid, input in_ready, dout, dout_valid, busy, ev_cnt);
  modport slave(input in_idx, in_valid, output in_ready, dout, dout_valid, busy, ev_cnt);
endinterface

// File: rtl/prio_dec_4to2_seq.sv
// prio_dec_4to2_seq: accepts an encoded index, holds its one-hot expansion HOLD cycles, then GAP dead cycles, counting events
module prio_dec_4to2_seq #(
  parameter int N = 2,
  parameter int HOLD = 3,
  parameter int GAP = 1
) (
  input logic clk,
  input logic reset_n,
  prio_dec_4to2_seq_if.slave bus
);
  localparam int W = 2**N;
  localparam int CW = $clog2(HOLD > GAP ? (HOLD > 2 ? HOLD : 2) : (GAP > 2 ? GAP : 2));
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP > 0 ? GAP - 1 : 0);
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [W-1:0] dout, dout_d;
  logic dv, dv_d;
  logic [7:0] ev, ev_d;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt <= '0;
      dout <= '0;
      dv <= 1'b0;
      ev <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      dout <= dout_d;
      dv <= dv_d;
      ev <= ev_d;
    end
  end
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    dout_d = dout;
    dv_d = dv;
    ev_d = ev;
    unique case (state)
      S_IDLE: if (bus.in_valid) begin
        dout_d = W'(1) << bus.in_idx;
        dv_d = 1'b1;
        cnt_d = HOLD_LD;
        ev_d = ev + 8'd1;
        state_d = S_HOLD;
      end
      S_HOLD: if (cnt != '0) cnt_d = cnt - 1'b1;
      else begin
        dout_d = '0;
        dv_d = 1'b0;
        cnt_d = GAP_LD;
        state_d = GAP == 0 ? S_IDLE : S_GAP;
      end
      S_GAP: if (cnt != '0) cnt_d = cnt - 1'b1;
      else state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  assign bus.in_ready = state == S_IDLE;
  assign bus.busy = state != S_IDLE;
  assign bus.dout = dout;
  assign bus.dout_valid = dv;
  assign bus.ev_cnt = ev;
endmodule

// File: tb/tb_prio_dec_4to2_seq.sv
// tb_prio_dec_4to2_seq: vector table, hand sequences and a random run against a cycle-age reference model
module tb_prio_dec_4to2_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic v = 1'b0;
  logic [1:0] idx = '0;
  int checks = 0;
  int errors = 0;
  int age[2] = '{1000, 1000};
  int midx[2] = '{0, 0};
  int mev[2] = '{0, 0};
  int mh[2] = '{3, 1};
  int mg[2] = '{1, 0};
  typedef struct {bit r; bit v; int idx; int d; bit rdy; int ev;} vec_t;
  vec_t tbl[12];
  prio_dec_4to2_seq_if #(.N(2)) ifa();
  prio_dec_4to2_seq_if #(.N(2)) ifb();
  assign ifa.in_valid = v;
  assign ifa.in_idx = idx;
  assign ifb.in_valid = v;
  assign ifb.in_idx = idx;
  prio_dec_4to2_seq #(.N(2), .HOLD(3), .GAP(1)) dut_a(.clk(clk), .reset_n(rst_n), .bus(ifa.slave));
  prio_dec_4to2_seq #(.N(2), .HOLD(1), .GAP(0)) dut_b(.clk(clk), .reset_n(rst_n), .bus(ifb.slave));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask
  task automatic step(input bit r, input bit vv, input int ii);
    rst_n = r;
    v = vv;
    idx = 2'(ii);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!r) begin
        age[i] = 1000;
        mev[i] = 0;
      end else if (vv && age[i] >= mh[i] + mg[i]) begin
        age[i] = 0;
        midx[i] = ii;
        mev[i] = (mev[i] + 1) % 256;
      end else if (age[i] < 1000) age[i]++;
    end
    @(negedge clk);
  endtask
  task automatic cmp_a(input string nm, input int d, input bit rdy, input int ev);
    chk({nm, " dout"}, int'(ifa.dout), d);
    chk({nm, " dout_valid"}, int'(ifa.dout_valid), int'(d != 0));
    chk({nm, " in_ready"}, int'(ifa.in_ready), int'(rdy));
    chk({nm, " busy"}, int'(ifa.busy), int'(!rdy));
    chk({nm, " ev_cnt"}, int'(ifa.ev_cnt), ev);
  endtask
  task automatic cmp_model(input string nm);
    int d;
    bit rdy;
    for (int i = 0; i < 2; i++) begin
      d = age[i] < mh[i] ? (1 << midx[i]) : 0;
      rdy = age[i] >= mh[i] + mg[i];
      chk($sformatf("%s[%0d] dout", nm, i), int'(i == 0 ? ifa.dout : ifb.dout), d);
      chk($sformatf("%s[%0d] dout_valid", nm, i), int'(i == 0 ? ifa.dout_valid : ifb.dout_valid), int'(d != 0));
      chk($sformatf("%s[%0d] in_ready", nm, i), int'(i == 0 ? ifa.in_ready : ifb.in_ready), int'(rdy));
      chk($sformatf("%s[%0d] busy", nm, i), int'(i == 0 ? ifa.busy : ifb.busy), int'(!rdy));
      chk($sformatf("%s[%0d] ev_cnt", nm, i), int'(i == 0 ? ifa.ev_cnt : ifb.ev_cnt), mev[i]);
    end
  endtask
  initial begin
    tbl[0] = '{0, 1, 0, 0, 1, 0};
    tbl[1] = '{0, 1, 0, 0, 1, 0};
    tbl[2] = '{1, 0, 2, 0, 1, 0};
    tbl[3] = '{1, 1, 2, 4, 0, 1};
    tbl[4] = '{1, 0, 2, 4, 0, 1};
    tbl[5] = '{1, 1, 3, 4, 0, 1};
    tbl[6] = '{1, 0, 0, 0, 0, 1};
    tbl[7] = '{1, 0, 0, 0, 1, 1};
    tbl[8] = '{1, 1, 1, 2, 0, 2};
    tbl[9] = '{1, 1, 3, 2, 0, 2};
    tbl[10] = '{0, 1, 3, 0, 1, 0};
    tbl[11] = '{1, 0, 0, 0, 1, 0};
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].idx);
      cmp_a($sformatf("vec%0d", i), tbl[i].d, tbl[i].rdy, tbl[i].ev);
    end
    for (int i = 0; i < 4; i++)
      for (int s = 0; s < 5; s++) begin
        step(1, 1, i);
        cmp_a($sformatf("b2b i%0d s%0d", i, s), s < 3 ? (1 << i) : 0, s == 4, i + 1);
      end
    step(0, 0, 0);
    cmp_model("wrap_rst");
    for (int s = 0; s < 512; s++) begin
      step(1, 1, int'($urandom_range(0, 3)));
      cmp_model("wrap");
      if (s == 0) chk("wrap first pulse", int'(ifb.dout_valid), 1);
      if (s == 1) chk("wrap pulse end", int'(ifb.dout_valid), 0);
    end
    chk("wrap ev_cnt_b", int'(ifb.ev_cnt), 0);
    for (int s = 0; s < 400; s++) begin
      step($urandom_range(0, 31) != 0, $urandom_range(0, 2) != 0, int'($urandom_range(0, 3)));
      cmp_model("rand");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
